// File: rtl/fetch_queue.sv
// fetch_queue: multi-slot instruction buffer between fetch and decode.
// Accepts up to PUSH_N entries per cycle and presents up to POP_N of the
// oldest entries in order. There is no bypass, so a pushed entry becomes
// visible one cycle later. A flush empties the buffer in a single cycle.
module fetch_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int PUSH_N = 2,
    parameter int POP_N  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [PUSH_N-1:0]            push_valid,
    input  logic [PUSH_N*DATA_W-1:0]     push_data,
    output logic                         push_ready,
    input  logic [$clog2(POP_N+1)-1:0]   pop_cnt,
    output logic [POP_N-1:0]             out_valid,
    output logic [POP_N*DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int POPC_W = $clog2(POP_N + 1);
    localparam int FREE_W = CNT_W + 1;

    localparam logic [FREE_W-1:0] DEPTH_F  = FREE_W'(DEPTH);
    localparam logic [FREE_W-1:0] PUSH_N_F = FREE_W'(PUSH_N);

    // Storage and pointer state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Per-cycle transfer amounts
    logic [FREE_W-1:0] free_w;
    logic              push_accept;
    logic [CNT_W-1:0]  n_push_req;
    logic [CNT_W-1:0]  n_push;
    logic [CNT_W-1:0]  n_pop;

    // Number of valid push slots; fetch keeps them contiguous from slot 0.
    function automatic logic [CNT_W-1:0] popcount_push(input logic [PUSH_N-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < PUSH_N; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Decode may ask for more entries than are present; only hand out what exists.
    function automatic logic [CNT_W-1:0] clamp_pop(input logic [POPC_W-1:0] req,
                                                   input logic [CNT_W-1:0]  occ);
        logic [CNT_W-1:0] r;
        r = CNT_W'(req);
        return (r > occ) ? occ : r;
    endfunction

    // Space check uses registered occupancy only, so it is independent of this cycle's pop.
    always_comb begin
        free_w      = DEPTH_F - {1'b0, count_q};
        push_ready  = (free_w >= PUSH_N_F);
        push_accept = push_ready && !flush;
        n_push_req  = popcount_push(push_valid);
        n_push      = push_accept ? n_push_req : '0;
        n_pop       = clamp_pop(pop_cnt, count_q);
    end

    // Next-state pointers and occupancy; a flush overrides any push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(n_pop);
            tail_d  = tail_q + PTR_W'(n_push);
            count_d = count_q + n_push - n_pop;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write; indices wrap modulo DEPTH through pointer truncation.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_N; i++) begin
            if (push_accept && (CNT_W'(i) < n_push_req)) begin
                mem_q[tail_q + PTR_W'(i)] <= push_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Present the oldest POP_N entries straight from registered state.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int j = 0; j < POP_N; j++) begin
            out_valid[j]                  = (CNT_W'(j) < count_q);
            out_data[j*DATA_W +: DATA_W]  = mem_q[head_q + PTR_W'(j)];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the buffer contents.
module tb_fetch_queue;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int PUSH_N = 2;
    localparam int POP_N  = 2;
    localparam int PCW    = $clog2(POP_N + 1);
    localparam int CNTW   = $clog2(DEPTH + 1);

    logic                       clk;
    logic                       reset;
    logic                       flush;
    logic [PUSH_N-1:0]          push_valid;
    logic [PUSH_N*DATA_W-1:0]   push_data;
    logic                       push_ready;
    logic [PCW-1:0]             pop_cnt;
    logic [POP_N-1:0]           out_valid;
    logic [POP_N*DATA_W-1:0]    out_data;
    logic [CNTW-1:0]            count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mq[$];

    fetch_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PUSH_N (PUSH_N),
        .POP_N  (POP_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_cnt    (pop_cnt),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_entry();
        return DATA_W'({$urandom(), $urandom()});
    endfunction

    // Compare every visible output against the model contents.
    task automatic compare_all();
        int sz;
        sz = mq.size();
        check_eq("count", DATA_W'(count), DATA_W'(sz));
        check_eq("push_ready", DATA_W'(push_ready), DATA_W'((DEPTH - sz) >= PUSH_N));
        for (int j = 0; j < POP_N; j++) begin
            check_eq($sformatf("out_valid[%0d]", j), DATA_W'(out_valid[j]), DATA_W'(j < sz));
            if (j < sz)
                check_eq($sformatf("out_data[%0d]", j), out_data[j*DATA_W +: DATA_W], mq[j]);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic cycle(input logic rst, input logic fl, input logic [PUSH_N-1:0] pv,
                         input logic [PUSH_N*DATA_W-1:0] pd, input logic [PCW-1:0] pc);
        int sz, np, nq;
        bit rdy;
        assert (pc <= POP_N) else $error("illegal pop_cnt %0d", pc);
        reset      = rst;
        flush      = fl;
        push_valid = pv;
        push_data  = pd;
        pop_cnt    = pc;
        if (rst || fl) begin
            mq.delete();
        end else begin
            sz  = mq.size();
            rdy = (DEPTH - sz) >= PUSH_N;
            np  = (int'(pc) < sz) ? int'(pc) : sz;
            repeat (np) void'(mq.pop_front());
            nq  = $countones(pv);
            if (rdy)
                for (int i = 0; i < nq; i++) mq.push_back(pd[i*DATA_W +: DATA_W]);
        end
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [PUSH_N*DATA_W-1:0] rnd_pair();
        return {rnd_entry(), rnd_entry()};
    endfunction

    initial begin
        logic [PUSH_N*DATA_W-1:0] pd;
        int r;
        reset = 1'b1; flush = 1'b0; push_valid = '0; push_data = '0; pop_cnt = '0;

        // Reset state
        cycle(1, 0, 2'b00, '0, 0);
        cycle(1, 0, 2'b00, '0, 0);
        check_eq("rst_count", DATA_W'(count), '0);
        check_eq("rst_out_valid", DATA_W'(out_valid), '0);
        check_eq("rst_push_ready", DATA_W'(push_ready), DATA_W'(1));

        // First pair of fetched instructions becomes visible next cycle
        pd = {32'hBFC00004, 32'h24020001, 32'hBFC00000, 32'h3C1D8000};
        cycle(0, 0, 2'b11, pd, 0);
        check_eq("t1_count", DATA_W'(count), DATA_W'(2));
        check_eq("t1_out_valid", DATA_W'(out_valid), DATA_W'(2'b11));
        check_eq("t1_pc0", DATA_W'(out_data[63:32]), DATA_W'(32'hBFC00000));
        check_eq("t1_pc1", DATA_W'(out_data[127:96]), DATA_W'(32'hBFC00004));

        // Fill to full; further push ignored
        for (int k = 0; k < 3; k++) cycle(0, 0, 2'b11, rnd_pair(), 0);
        check_eq("full_count", DATA_W'(count), DATA_W'(8));
        check_eq("full_ready", DATA_W'(push_ready), '0);
        cycle(0, 0, 2'b11, rnd_pair(), 0);
        check_eq("full_hold", DATA_W'(count), DATA_W'(8));

        // count=7 still rejects a pair; pop with push in same cycle still rejects
        cycle(0, 0, 2'b00, '0, 1);
        check_eq("c7_count", DATA_W'(count), DATA_W'(7));
        check_eq("c7_ready", DATA_W'(push_ready), '0);
        cycle(0, 0, 2'b11, rnd_pair(), 0);
        cycle(0, 0, 2'b11, rnd_pair(), 2);
        check_eq("c5_count", DATA_W'(count), DATA_W'(5));

        // Flush wins over simultaneous push and pop
        cycle(0, 1, 2'b11, rnd_pair(), 2);
        check_eq("flush_count", DATA_W'(count), '0);
        check_eq("flush_valid", DATA_W'(out_valid), '0);
        cycle(0, 0, 2'b11, rnd_pair(), 0);
        check_eq("post_flush_count", DATA_W'(count), DATA_W'(2));

        // Move head to 6, refill across the wrap, drain in order
        cycle(0, 0, 2'b11, rnd_pair(), 0);
        cycle(0, 0, 2'b11, rnd_pair(), 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2'b00, '0, 2);
        check_eq("wrap_empty", DATA_W'(count), '0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2'b11, rnd_pair(), 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2'b00, '0, 2);

        // Clamping at low occupancy
        cycle(0, 0, 2'b01, rnd_pair(), 0);
        check_eq("one_count", DATA_W'(count), DATA_W'(1));
        cycle(0, 0, 2'b00, '0, 2);
        check_eq("clamp_count", DATA_W'(count), '0);
        cycle(0, 0, 2'b00, '0, 1);
        check_eq("underflow_count", DATA_W'(count), '0);
        check_eq("underflow_ready", DATA_W'(push_ready), DATA_W'(1));

        // Randomized traffic including flushes and resets
        for (int k = 0; k < 600; k++) begin
            logic [PUSH_N-1:0] pv;
            r  = $urandom_range(0, 2);
            pv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0), pv,
                  rnd_pair(), PCW'($urandom_range(0, POP_N)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction buffer between fetch and decode; the next generation of the single-entry fetch→decode register.
- Decouples fetch (stalled by i_data_ok) from decode (stalled by hazards).
- Accepts up to PUSH_N {pc, instr} entries per cycle and presents up to POP_N oldest entries to decode in order.
- A flush from the exception, eret or branch-redirect logic empties it in one cycle.

Parameters:
- DATA_W, 64, entry width (pc in [63:32], instr in [31:0] by default packing).
- DEPTH, 8, number of entries; power of 2, ≥ max(PUSH_N, POP_N).
- PUSH_N, 2, max entries written per cycle.
- POP_N, 2, max entries read per cycle.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all contents this cycle.
- push_valid  input  PUSH_N  per-slot valid; must be contiguous from bit 0 (e.g. 01, 11; never 10).
- push_data  input  PUSH_N*DATA_W  slot i occupies bits [i*DATA_W +: DATA_W]; slot 0 is oldest.
- push_ready  output  1  high when free slots ≥ PUSH_N.
- pop_cnt  input  $clog2(POP_N+1)  number of entries decode consumes this cycle.
- out_valid  output  POP_N  bit j high when entry head+j is occupied.
- out_data  output  POP_N*DATA_W  entry head+j in slot j; slot 0 is oldest.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage and pointers:
  - Register array mem[DEPTH].
  - head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count holds 0..DEPTH.
- Reset (synchronous, active-high): head=0, tail=0, count=0, so out_valid=0 and push_ready=1. mem contents are don't-care; out_data is don't-care while out_valid=0.
- push_ready = (DEPTH - count) ≥ PUSH_N. It is computed from the registered count only, with no dependence on pop_cnt this cycle.
- Push:
  - Accepted when push_ready=1 and flush=0.
  - n_push = popcount(push_valid).
  - mem[(tail+i) mod DEPTH] ← slot i for i < n_push; then tail += n_push.
  - When push_ready=0, pushes are ignored with no error; fetch must hold.
- Pop:
  - n_pop = min(pop_cnt, count); a request beyond occupancy is clamped.
  - head += n_pop.
  - pop_cnt values > POP_N are illegal; the bench asserts on them.
- Output: out_valid[j] = (j < count); out_data slot j = mem[(head+j) mod DEPTH]. Both are combinational from registered state, so the queue adds 1 cycle of latency from push to visibility.
- No bypass: an entry pushed in cycle t is first visible in cycle t+1, even when the queue was empty.
- Simultaneous push and pop: count_next = count + n_push − n_pop. The pop uses pre-push contents.
- Full: push_ready=0 whenever free < PUSH_N; a partially free queue still rejects.
- Empty: out_valid=0; pop_cnt is clamped to 0.
- Flush:
  - Priority: reset > flush > push/pop.
  - Next cycle: head=tail=0 and count=0. Push and pop in the flush cycle are discarded.
  - The queue accepts pushes again in the cycle after flush.
- Wrap-around: a push or pop straddling index DEPTH−1→0 splits naturally through the modulo indexing, with no bubble.
- Reset during operation discards everything, exactly as at power-up.

Test Plan:
- Reset, then push_valid=11 with pcs 0xBFC00000/0xBFC00004 at t0 → count=0 and out_valid=00 at t0; at t1 count=2, out_valid=11, slot0 pc=0xBFC00000, slot1 pc=0xBFC00004.
- Push 11 each cycle with pop_cnt=0 → count 2,4,6; push_ready drops once count=8 (DEPTH=8, PUSH_N=2); a further push is ignored and count stays 8.
- count=7, push 11 → push_ready=0 and the push is ignored. Then pop_cnt=2 with push 11 in the same cycle → push is still rejected because push_ready uses pre-pop count; count=5 next cycle.
- Fill to count=6 starting at head=6, then pop 2 per cycle → the order is preserved across the wrap 7→0, and slot0/slot1 straddle indices 7 and 0 correctly.
- count=5, flush=1 with push 11 and pop_cnt=2 in the same cycle → next cycle count=0, out_valid=00, head=tail=0; a push the cycle after appears at t+2.
- count=1, pop_cnt=2 → n_pop clamps to 1 and count=0. Then pop_cnt=1 with count=0 → no change, no pointer underflow.
